// File: rtl/mc_sequencer_if.sv
// Handshake and strobe bundle between the RV32I multicycle datapath and its sequencer.
interface mc_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             Run;
  logic [6:0]       OpCode;
  logic             imem_ready;
  logic             dmem_ready;
  logic             IMRd;
  logic             IRWr;
  logic             PCWr;
  logic             RUWr;
  logic             DMRd;
  logic             DMWr;
  logic             Halt;
  logic             Trap;
  logic [2:0]       State;
  logic [CNT_W-1:0] InstRet;

  // Datapath / environment side.
  modport master (
    output Run, OpCode, imem_ready, dmem_ready,
    input  IMRd, IRWr, PCWr, RUWr, DMRd, DMWr, Halt, Trap, State, InstRet
  );

  // Sequencer side.
  modport slave (
    input  Run, OpCode, imem_ready, dmem_ready,
    output IMRd, IRWr, PCWr, RUWr, DMRd, DMWr, Halt, Trap, State, InstRet
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// fires the state-changing strobes, stalls on memory ready and counts retirements.
module mc_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StTrap   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBranch
  } cls_e;

  state_e           state_q;
  cls_e             cls_q;
  logic             halt_q;
  logic             trap_q;
  logic [CNT_W-1:0] instret_q;

  cls_e dec_cls;
  logic dec_sys;
  logic dec_ill;

  logic imrd;
  logic irwr;
  logic pcwr;
  logic ruwr;
  logic dmrd;
  logic dmwr;

  // Classify the opcode currently presented by IR; only consumed in DECODE.
  always_comb begin
    dec_cls = ClsAlu;
    dec_sys = 1'b0;
    dec_ill = 1'b0;
    case (bus.OpCode)
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: dec_cls = ClsAlu;
      7'b0000011:                          dec_cls = ClsLoad;
      7'b0100011:                          dec_cls = ClsStore;
      7'b1100011:                          dec_cls = ClsBranch;
      7'b1110011:                          dec_sys = 1'b1;
      default:                             dec_ill = 1'b1;
    endcase
  end

  // Strobes are combinational from state and same-cycle handshakes; forced low in reset.
  always_comb begin
    imrd = 1'b0;
    irwr = 1'b0;
    pcwr = 1'b0;
    ruwr = 1'b0;
    dmrd = 1'b0;
    dmwr = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          imrd = bus.Run;
          irwr = bus.Run & bus.imem_ready;
        end
        StExec: pcwr = (cls_q == ClsBranch);
        StMem: begin
          dmrd = (cls_q == ClsLoad);
          dmwr = (cls_q == ClsStore);
          pcwr = (cls_q == ClsStore) & bus.dmem_ready;
        end
        StWb: begin
          ruwr = 1'b1;
          pcwr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM, latched instruction class, sticky halt/trap flags and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cls_q     <= ClsAlu;
      halt_q    <= 1'b0;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      // Every PC update marks exactly one retired instruction.
      if (pcwr) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      unique case (state_q)
        StFetch: begin
          if (bus.Run && bus.imem_ready) begin
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (dec_sys) begin
            state_q <= StHalt;
            halt_q  <= 1'b1;
          end else if (dec_ill) begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
          end else begin
            // Path is frozen here so later OpCode changes cannot redirect it.
            cls_q   <= dec_cls;
            state_q <= StExec;
          end
        end
        StExec: begin
          unique case (cls_q)
            ClsBranch:         state_q <= StFetch;
            ClsLoad, ClsStore: state_q <= StMem;
            default:           state_q <= StWb;
          endcase
        end
        StMem: begin
          if (bus.dmem_ready) begin
            state_q <= (cls_q == ClsLoad) ? StWb : StFetch;
          end
        end
        StWb:   state_q <= StFetch;
        StHalt: ;
        StTrap: ;
        default: begin
          state_q <= StTrap;
          trap_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.IMRd    = imrd;
  assign bus.IRWr    = irwr;
  assign bus.PCWr    = pcwr;
  assign bus.RUWr    = ruwr;
  assign bus.DMRd    = dmrd;
  assign bus.DMWr    = dmwr;
  assign bus.Halt    = halt_q;
  assign bus.Trap    = trap_q;
  assign bus.State   = state_q;
  assign bus.InstRet = instret_q;

endmodule
